// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } sub_state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor, same gate-level form as the adder cell.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic x_xor_y;

  assign x_xor_y = x ^ y;
  assign d       = x_xor_y ^ bin;
  // Borrow when x < y, or when the bits tie and a borrow is already pending.
  assign bout    = (~x & y) | (~x_xor_y & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor cell plus a registered borrow.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  sub_state_t       state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_d;
  logic [WIDTH-1:0] diff_q;
  logic [CntW-1:0]  cnt_q;
  logic             bor_q;
  logic             a_msb_q, b_msb_q;
  logic             bout_q, ovf_q, ovf_d;
  logic             in_ready_q, out_valid_q;
  logic             cell_d, cell_bout;

  full_subtractor u_cell (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .bin  (bor_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Next result word and overflow flag from the current cell output.
  always_comb begin
    res_d = {cell_d, res_q[WIDTH-1:1]};
    // On the last bit cell_d is the result MSB.
    ovf_d = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      bor_q       <= 1'b0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= b;
            a_msb_q    <= a[WIDTH-1];
            b_msb_q    <= b[WIDTH-1];
            bor_q      <= 1'b0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= StRun;
          end
        end
        StRun: begin
          res_q <= res_d;
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          bor_q <= cell_bout;
          if (cnt_q == CntLast) begin
            diff_q      <= res_d;
            bout_q      <= cell_bout;
            ovf_q       <= ovf_d;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases plus randomized traffic
// checked every cycle against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] d;
    logic         b;
    logic         o;
  } res_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic.
  function automatic res_t ref_sub(input logic [W-1:0] x, input logic [W-1:0] y);
    res_t r;
    int   sd;
    sd  = int'($signed(x)) - int'($signed(y));
    r.d = x - y;
    r.b = (x < y);
    r.o = (sd > 127) || (sd < -128);
    return r;
  endfunction

  // Model state: one operation in flight at most.
  res_t q[$];
  logic busy    = 1'b0;
  logic armed   = 1'b0;
  int   acc_edge = 0;

  // Compare every cycle on the falling edge, then advance the model.
  always @(negedge clk) begin
    logic exp_rdy, exp_ov;
    exp_rdy = !busy;
    exp_ov  = busy && (cyc >= acc_edge + W);
    if (armed) begin
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      if (exp_ov && q.size() > 0) begin
        chk("diff", 32'(diff), 32'(q[0].d));
        chk("bout", 32'(bout), 32'(q[0].b));
        chk("ovf", 32'(ovf), 32'(q[0].o));
      end
    end
    if (rst) begin
      armed = 1'b1;
      busy  = 1'b0;
      q.delete();
    end else if (!busy && in_valid) begin
      q.push_back(ref_sub(a, b));
      busy     = 1'b1;
      acc_edge = cyc + 1;
    end else if (exp_ov && out_ready) begin
      void'(q.pop_front());
      busy = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  // Directed operation with literal expectations; hold>0 applies backpressure in DONE.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] ed, input logic eb, input logic eo,
                       input int hold);
    int n;
    wait_ready();
    in_valid = 1'b1;
    a = av;
    b = bv;
    tick();
    in_valid  = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    out_ready = (hold == 0);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk("latency", 32'(n), 32'(W));
    chk("lit_diff", 32'(diff), 32'(ed));
    chk("lit_bout", 32'(bout), 32'(eb));
    chk("lit_ovf", 32'(ovf), 32'(eo));
    if (hold > 0) begin
      repeat (hold) tick();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_diff", 32'(diff), 32'(ed));
      chk("hold_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      tick();
      chk("release_idle", 32'(in_ready), 32'd1);
      chk("release_valid", 32'(out_valid), 32'd0);
    end else begin
      tick();
    end
    out_ready = 1'b0;
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] c [4];
    c[0] = 8'h00;
    c[1] = 8'h7F;
    c[2] = 8'h80;
    c[3] = 8'hFF;
    if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 3)];
    return W'($urandom);
  endfunction

  initial begin
    int last;
    int t;
    int seen;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);

    do_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 0);
    do_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 0);
    do_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 0);
    do_op(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 0);
    do_op(8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1, 5);

    // Reset four cycles after accept.
    wait_ready();
    in_valid = 1'b1;
    a = 8'h10;
    b = 8'h01;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_bout", 32'(bout), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (20) begin
      tick();
      if (out_valid) seen = 1;
    end
    chk("abort_no_valid", 32'(seen), 32'd0);
    out_ready = 1'b0;
    do_op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 0);

    // Back-to-back with in_valid held high.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    a = pick();
    b = pick();
    last = 0;
    for (int i = 0; i < 6; i++) begin
      wait_ready();
      t = cyc;
      if (i > 0) chk("b2b_spacing", 32'(t - last), 32'(W + 2));
      last = t;
      tick();
      a = pick();
      b = pick();
    end
    in_valid = 1'b0;
    repeat (W + 4) tick();

    // Randomized traffic with random backpressure and rare resets.
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      a         = pick();
      b         = pick();
      out_ready = ($urandom_range(0, 2) != 0);
      rst       = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (W + 4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor computing `a - b` one bit per cycle, LSB first, through a single full-subtractor cell and a registered borrow. It is the subtract-direction counterpart of the team's ripple-carry adder datapath, trading area for latency. Operands enter and results leave through valid/ready handshakes so the block can sit between pipelined producers and consumers.

## Interface
- `WIDTH`, 8, operand and result width in bits; legal values are ≥2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands `a`/`b` are valid.
- `in_ready`  out  1  block can accept operands; high only in IDLE.
- `a`  in  WIDTH  minuend, sampled on the input handshake only.
- `b`  in  WIDTH  subtrahend, sampled on the input handshake only.
- `out_valid`  out  1  result is valid; high only in DONE.
- `out_ready`  in  1  consumer accepts the result.
- `diff`  out  WIDTH  `(a - b) mod 2^WIDTH`.
- `bout`  out  1  final borrow; 1 when unsigned `a < b`.
- `ovf`  out  1  signed two's-complement overflow.

## Operation
- States are IDLE, RUN and DONE. Reset forces IDLE with `diff=0`, `bout=0`, `ovf=0`, `out_valid=0`, `in_ready=1`, the borrow register at 0 and the bit counter at 0.
- **IDLE:** when `in_valid && in_ready`, latch `a` into shift register A and `b` into shift register B. Clear the borrow and the counter, then go to RUN.
- **RUN, every cycle:**
  - The cell computes `d = A[0]^B[0]^bor` and `bor' = (~A[0]&B[0]) | (~(A[0]^B[0])&bor)`.
  - `d` is shifted into the MSB of the result register, and A and B shift right by one.
  - The counter increments.
  - When the counter reaches WIDTH-1, register the last bit and go to DONE.
- **DONE:**
  - `bout` is the final borrow.
  - `ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1])`. The original operand MSBs are held in two dedicated flops captured at accept.
  - `diff`, `bout` and `ovf` stay stable while `out_valid` is high and `out_ready` is low.
  - When `out_ready` is high, go to IDLE.
  - `diff`, `bout` and `ovf` keep their values until the next accept; only `out_valid` carries meaning.
- `in_ready` is 0 in RUN and DONE, so a new accept can never coincide with result consumption.
- `a` and `b` changing outside the accept cycle have no effect.
- Asserting `rst` in RUN or DONE aborts the operation on that edge and returns the block to the reset state. The partial result is discarded and no `out_valid` is produced.
- `in_valid` held high after an accept is not an accept again until the block is back in IDLE.

## Timing
- The accept edge is edge 0; `out_valid` rises after edge WIDTH, giving a latency of WIDTH cycles from accept to valid.
- With `out_ready` tied high, `out_valid` is a single-cycle pulse. `in_ready` rises the cycle after that pulse, so the minimum initiation interval is WIDTH+2 cycles.
- The counter is `$clog2(WIDTH)` bits wide and never wraps during RUN.
- All outputs are registered; there is no combinational path from an input to an output.

## Structure
- **Package `serial_sub_pkg`:**
  - state enum `sub_state_t` with IDLE, RUN and DONE;
  - `DEFAULT_WIDTH = 8`.
- **Sub-module `full_subtractor`:** purely combinational, with inputs x, y, bin and outputs d, bout. It uses the same gate-level style as the adder cell and is instantiated once.
- **Top level:** FSM, shift registers A, B and result, borrow flop, counter, MSB capture flops, and output registers.

## Test plan
- **Basic subtract:** WIDTH=8, a=0x05, b=0x03 → `diff=0x02`, `bout=0`, `ovf=0`. `out_valid` is first high exactly 8 cycles after accept.
- **Borrow out:** a=0x03, b=0x05 → `diff=0xFE`, `bout=1`, `ovf=0`.
- **Signed overflow and equal operands:**
  - a=0x80, b=0x01 → `diff=0x7F`, `bout=0`, `ovf=1`.
  - a=0xFF, b=0xFF → `diff=0x00`, `bout=0`, `ovf=0`.
- **Backpressure:** hold `out_ready=0` for 5 cycles in DONE → `out_valid` and `diff` stay stable and `in_ready` stays 0. On release, return to IDLE the next cycle.
- **Reset mid-operation:** assert `rst` 4 cycles after accepting a=0x10, b=0x01 → all outputs return to reset values, and no `out_valid` appears within 20 cycles. A following accept of a=0x10, b=0x01 gives `diff=0x0F`.
- **Back-to-back:** keep `in_valid=1` with a new operand pair for each accept and `out_ready=1` → each result matches its own pair, and accepts are spaced exactly WIDTH+2 cycles apart.
